dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encodings and word constants.
package dmem_arbiter_pkg;

  localparam int unsigned WordWidth = 32;
  localparam logic [WordWidth-1:0] WORD_ZERO = '0;

  typedef enum logic [1:0] {
    DmaIdle   = 2'b00,
    DmaAccess = 2'b01,
    DmaResp   = 2'b10
  } dma_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory bus bundle for dmem_arbiter; slave is the arbiter view, master the
// surrounding system (requesters plus data memory).
interface dmem_arbiter_if;

  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic [31:0] rdata1;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way grant: round-robin on last_grant, or port 0 wins ties when FIXED_PRIO.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters: latch a grant, run one memory
// access, then pulse the winner's ack with captured read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned IDX_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  dma_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        lat_id_q, lat_id_d;
  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        grant_valid;
  logic        grant_id;
  logic [31:0] sel_addr;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arb2 (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_addr = grant_id ? bus.addr1 : bus.addr0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_id_d     = lat_id_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      DmaIdle: begin
        if (grant_valid) begin
          state_d      = DmaAccess;
          last_grant_d = grant_id;
          lat_id_d     = grant_id;
          lat_we_d     = grant_id ? bus.we1 : bus.we0;
          lat_wdata_d  = grant_id ? bus.wdata1 : bus.wdata0;
          // Only the index bits reach the memory; the rest read back as zero.
          lat_addr_d                 = WORD_ZERO;
          lat_addr_d[IDX_WIDTH-1:0]  = sel_addr[IDX_WIDTH-1:0];
        end
      end
      DmaAccess: begin
        state_d = DmaResp;
        if (!lat_we_q) begin
          if (lat_id_q) begin
            rdata1_d = bus.mem_read_data;
          end else begin
            rdata0_d = bus.mem_read_data;
          end
        end
      end
      DmaResp: begin
        state_d = DmaIdle;
      end
      default: begin
        state_d = DmaIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DmaIdle;
      last_grant_q <= 1'b1;
      lat_id_q     <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= WORD_ZERO;
      lat_wdata_q  <= WORD_ZERO;
      rdata0_q     <= WORD_ZERO;
      rdata1_q     <= WORD_ZERO;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_id_q     <= lat_id_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  logic in_access;
  assign in_access = (state_q == DmaAccess);

  // Strobes are gated by rst so a reset landing in ACCESS never commits a write.
  always_comb begin
    bus.mem_read       = in_access & ~lat_we_q & ~rst;
    bus.mem_write      = in_access & lat_we_q & ~rst;
    bus.mem_address    = in_access ? lat_addr_q : WORD_ZERO;
    bus.mem_write_data = in_access ? lat_wdata_q : WORD_ZERO;
    bus.ack0           = (state_q == DmaResp) & ~lat_id_q;
    bus.ack1           = (state_q == DmaResp) & lat_id_q;
    bus.rdata0         = rdata0_q;
    bus.rdata1         = rdata1_q;
  end

endmodule
